serial_operand_feeder: RTL and testbench



---
 rtl/serial_operand_feeder.sv | 110 +++++++++++
 tb/tb_serial_operand_feeder.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_operand_feeder.sv
// Parallel-to-serial operand feeder for the bit-serial adder: streams (a, b) LSB-first
// with first/last framing, plus a one-entry pending buffer so back-to-back words have no bubble.
module serial_operand_feeder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             bit_valid,
  input  logic             bit_ready,
  output logic             a_bit,
  output logic             b_bit,
  output logic             first_bit,
  output logic             last_bit,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]       state;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-1:0] pend_a;
  logic [WIDTH-1:0] pend_b;
  logic [CW-1:0]    cnt;
  logic             pend_full;

  logic accept;
  logic beat;
  logic word_done;

  // in_ready is gated by rst so nothing is accepted while reset is held.
  assign in_ready  = !pend_full && !rst;
  assign accept    = in_valid && in_ready;
  assign bit_valid = (state == SHIFT);
  assign beat      = bit_valid && bit_ready;
  assign word_done = beat && (cnt == CNT_LAST);

  assign a_bit     = bit_valid && sh_a[0];
  assign b_bit     = bit_valid && sh_b[0];
  assign first_bit = bit_valid && (cnt == '0);
  assign last_bit  = bit_valid && (cnt == CNT_LAST);
  assign busy      = (state == SHIFT) || pend_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sh_a      <= '0;
      sh_b      <= '0;
      pend_a    <= '0;
      pend_b    <= '0;
      cnt       <= '0;
      pend_full <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // A full pending slot cannot coexist with IDLE, but drain it first if it ever does.
          if (pend_full) begin
            sh_a      <= pend_a;
            sh_b      <= pend_b;
            cnt       <= '0;
            pend_full <= 1'b0;
            state     <= SHIFT;
          end else if (accept) begin
            sh_a  <= a;
            sh_b  <= b;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (word_done) begin
            cnt <= '0;
            if (pend_full) begin
              sh_a      <= pend_a;
              sh_b      <= pend_b;
              pend_full <= 1'b0;
            end else if (accept) begin
              sh_a <= a;
              sh_b <= b;
            end else begin
              state <= IDLE;
            end
          end else begin
            if (beat) begin
              sh_a <= {1'b0, sh_a[WIDTH-1:1]};
              sh_b <= {1'b0, sh_b[WIDTH-1:1]};
              cnt  <= cnt + CW'(1);
            end
            // Mid-word accepts park in the pending slot until the current word finishes.
            if (accept) begin
              pend_a    <= a;
              pend_b    <= b;
              pend_full <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_operand_feeder.sv
// Directed bench for serial_operand_feeder: WIDTH=4 and WIDTH=8 instances sharing clk/rst.
module tb_serial_operand_feeder;

  logic       clk = 1'b0;
  logic       rst;

  logic       in_valid, in_ready, bit_valid, bit_ready;
  logic [3:0] a, b;
  logic       a_bit, b_bit, first_bit, last_bit, busy;

  logic       in_valid8, in_ready8, bit_valid8, bit_ready8;
  logic [7:0] a8, b8;
  logic       a_bit8, b_bit8, first_bit8, last_bit8, busy8;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  serial_operand_feeder #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .bit_valid(bit_valid), .bit_ready(bit_ready), .a_bit(a_bit), .b_bit(b_bit),
    .first_bit(first_bit), .last_bit(last_bit), .busy(busy)
  );

  serial_operand_feeder #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .a(a8), .b(b8),
    .bit_valid(bit_valid8), .bit_ready(bit_ready8), .a_bit(a_bit8), .b_bit(b_bit8),
    .first_bit(first_bit8), .last_bit(last_bit8), .busy(busy8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bt(input string tag, input logic ea, input logic eb, input logic ef, input logic el);
    chk({tag, ".valid"}, 32'(bit_valid), 32'd1);
    chk({tag, ".a_bit"}, 32'(a_bit), 32'(ea));
    chk({tag, ".b_bit"}, 32'(b_bit), 32'(eb));
    chk({tag, ".first"}, 32'(first_bit), 32'(ef));
    chk({tag, ".last"},  32'(last_bit), 32'(el));
  endtask

  task automatic bt8(input string tag, input logic ea, input logic eb, input logic ef, input logic el);
    chk({tag, ".valid"}, 32'(bit_valid8), 32'd1);
    chk({tag, ".a_bit"}, 32'(a_bit8), 32'(ea));
    chk({tag, ".b_bit"}, 32'(b_bit8), 32'(eb));
    chk({tag, ".first"}, 32'(first_bit8), 32'(ef));
    chk({tag, ".last"},  32'(last_bit8), 32'(el));
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, ".valid"}, 32'(bit_valid), 32'd0);
    chk({tag, ".busy"},  32'(busy), 32'd0);
    chk({tag, ".a_bit"}, 32'(a_bit), 32'd0);
    chk({tag, ".first"}, 32'(first_bit), 32'd0);
    chk({tag, ".last"},  32'(last_bit), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 0; a = '0; b = '0; bit_ready = 1'b1;
    in_valid8 = 0; a8 = '0; b8 = '0; bit_ready8 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    // Reset state
    idle_chk("rst");
    chk("rst.in_ready", 32'(in_ready), 32'd0);
    chk("rst.b_bit", 32'(b_bit), 32'd0);
    chk("rst8.valid", 32'(bit_valid8), 32'd0);
    chk("rst8.in_ready", 32'(in_ready8), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst.in_ready", 32'(in_ready), 32'd1);

    // Single word: a=1000 b=0110
    in_valid = 1; a = 4'b1000; b = 4'b0110;
    chk("t1.idle_valid", 32'(bit_valid), 32'd0);
    step();
    in_valid = 0;
    bt("t1.b0", 0, 0, 1, 0); step();
    bt("t1.b1", 0, 1, 0, 0); step();
    bt("t1.b2", 0, 1, 0, 0); step();
    bt("t1.b3", 1, 0, 0, 1); step();
    idle_chk("t1.end");

    // Back-to-back: (1000,0110) then (0011,0101)
    in_valid = 1; a = 4'b1000; b = 4'b0110;
    step();
    a = 4'b0011; b = 4'b0101;
    chk("t2.rdy_w2", 32'(in_ready), 32'd1);
    bt("t2.w1b0", 0, 0, 1, 0); step();
    in_valid = 0; a = '0; b = '0;
    chk("t2.rdy_b1", 32'(in_ready), 32'd0);
    chk("t2.busy", 32'(busy), 32'd1);
    bt("t2.w1b1", 0, 1, 0, 0); step();
    chk("t2.rdy_b2", 32'(in_ready), 32'd0);
    bt("t2.w1b2", 0, 1, 0, 0); step();
    chk("t2.rdy_b3", 32'(in_ready), 32'd0);
    bt("t2.w1b3", 1, 0, 0, 1); step();
    chk("t2.rdy_w2b0", 32'(in_ready), 32'd1);
    bt("t2.w2b0", 1, 1, 1, 0); step();
    bt("t2.w2b1", 1, 0, 0, 0); step();
    bt("t2.w2b2", 0, 1, 0, 0); step();
    bt("t2.w2b3", 0, 0, 0, 1); step();
    idle_chk("t2.end");

    // Stall at beat 2 of a=1010
    in_valid = 1; a = 4'b1010; b = 4'b0000;
    step();
    in_valid = 0;
    bt("t3.b0", 0, 0, 1, 0); step();
    bt("t3.b1", 1, 0, 0, 0); step();
    bit_ready = 0;
    for (int i = 0; i < 3; i++) begin
      bt("t3.stall", 0, 0, 0, 0);
      chk("t3.cnt", 32'(u4.cnt), 32'd2);
      step();
    end
    bit_ready = 1;
    bt("t3.b2", 0, 0, 0, 0); step();
    bt("t3.b3", 1, 0, 0, 1); step();
    idle_chk("t3.end");

    // Buffer full: w1=(0101,0011) shifting, w2=(1100,1001) pending, w3=(0110,1111) waiting
    in_valid = 1; a = 4'b0101; b = 4'b0011;
    step();
    a = 4'b1100; b = 4'b1001;
    bt("t4.w1b0", 1, 1, 1, 0); step();
    a = 4'b0110; b = 4'b1111;
    chk("t4.rdy_full1", 32'(in_ready), 32'd0);
    bt("t4.w1b1", 0, 1, 0, 0); step();
    chk("t4.rdy_full2", 32'(in_ready), 32'd0);
    bt("t4.w1b2", 1, 0, 0, 0); step();
    chk("t4.rdy_full3", 32'(in_ready), 32'd0);
    bt("t4.w1b3", 0, 0, 0, 1); step();
    chk("t4.rdy_free", 32'(in_ready), 32'd1);
    bt("t4.w2b0", 0, 1, 1, 0); step();
    in_valid = 0; a = '0; b = '0;
    chk("t4.rdy_w3pend", 32'(in_ready), 32'd0);
    bt("t4.w2b1", 0, 0, 0, 0); step();
    bt("t4.w2b2", 1, 0, 0, 0); step();
    bt("t4.w2b3", 1, 1, 0, 1); step();
    bt("t4.w3b0", 0, 1, 1, 0); step();
    bt("t4.w3b1", 1, 1, 0, 0); step();
    bt("t4.w3b2", 1, 1, 0, 0); step();
    bt("t4.w3b3", 0, 1, 0, 1); step();
    idle_chk("t4.end");

    // Reset mid-word with a word pending
    in_valid = 1; a = 4'b0101; b = 4'b0101;
    step();
    a = 4'b1111; b = 4'b1111;
    bt("t5.b0", 1, 1, 1, 0); step();
    in_valid = 0; a = '0; b = '0;
    bt("t5.b1", 0, 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    idle_chk("t5.async");
    chk("t5.in_ready", 32'(in_ready), 32'd0);
    step();
    rst = 1'b0;
    step();
    idle_chk("t5.rel1");
    step();
    idle_chk("t5.rel2");
    in_valid = 1; a = 4'b1111; b = 4'b0000;
    step();
    in_valid = 0;
    bt("t5.n0", 1, 0, 1, 0); step();
    bt("t5.n1", 1, 0, 0, 0); step();
    bt("t5.n2", 1, 0, 0, 0); step();
    bt("t5.n3", 1, 0, 0, 1); step();
    idle_chk("t5.end");

    // WIDTH=8: a=81 b=7E
    in_valid8 = 1; a8 = 8'h81; b8 = 8'h7E;
    chk("t6.in_ready", 32'(in_ready8), 32'd1);
    step();
    in_valid8 = 0;
    bt8("t6.b0", 1, 0, 1, 0); step();
    for (int i = 1; i < 7; i++) begin
      bt8("t6.mid", 0, 1, 0, 0);
      step();
    end
    bt8("t6.b7", 1, 0, 0, 1); step();
    chk("t6.end_valid", 32'(bit_valid8), 32'd0);
    chk("t6.end_busy", 32'(busy8), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
